// File: rtl/traffic_conflict_monitor.sv
// Safety monitor for a 4-way light controller: checks encoding, conflicts, G->Y->R order and yellow length.
// Define TLC_MON_STATS_EN to add the saturating fault_count statistics port.
module traffic_conflict_monitor #(
  parameter int unsigned MIN_YELLOW      = 20,
  parameter int unsigned CONFLICT_FILTER = 2,
  parameter int unsigned FLASH_HALF      = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_N,
  input  logic [2:0] light_E,
  input  logic [2:0] light_S,
  input  logic [2:0] light_W,
  input  logic       fault_ack,
  output logic [2:0] out_N,
  output logic [2:0] out_E,
  output logic [2:0] out_S,
  output logic [2:0] out_W,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] fault_dir
`ifdef TLC_MON_STATS_EN
  ,
  output logic [7:0] fault_count
`endif
);

  localparam logic [2:0] LIGHT_G = 3'b001;
  localparam logic [2:0] LIGHT_Y = 3'b010;
  localparam logic [2:0] LIGHT_R = 3'b100;
  localparam int unsigned YW = $clog2(MIN_YELLOW + 1);
  localparam int unsigned PW = $clog2(CONFLICT_FILTER + 1);
  localparam int unsigned FW = $clog2(2 * FLASH_HALF);

  typedef enum logic {RUN = 1'b0, FLASH = 1'b1} state_t;

  state_t          state;
  logic [2:0]      lt    [4];
  logic [2:0]      prev  [4];
  logic [2:0]      out_r [4];
  logic [YW-1:0]   ycnt  [4];
  logic [PW-1:0]   pcnt;
  logic [FW-1:0]   fcnt;
  logic [FW-1:0]   fcnt_nxt;

  logic [3:0] inv_v, act_v, skip_v, order_v, short_v;
  logic       conf, bad_in, filt_hit, hit;
  logic [2:0] hit_code;
  logic [1:0] hit_dir;

  function automatic logic [1:0] lowest(input logic [3:0] v);
    lowest = 2'd0;
    for (int unsigned i = 0; i < 4; i++)
      if (v[3-i]) lowest = 2'(3 - i);
  endfunction

  always_comb begin
    lt[0] = light_N;
    lt[1] = light_E;
    lt[2] = light_S;
    lt[3] = light_W;
  end

  always_comb begin
    inv_v   = '0;
    act_v   = '0;
    skip_v  = '0;
    order_v = '0;
    short_v = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      inv_v[i]   = !(lt[i] == LIGHT_G || lt[i] == LIGHT_Y || lt[i] == LIGHT_R);
      act_v[i]   = (lt[i] == LIGHT_G) || (lt[i] == LIGHT_Y);
      skip_v[i]  = (prev[i] == LIGHT_G) && (lt[i] == LIGHT_R);
      order_v[i] = ((prev[i] == LIGHT_R) && (lt[i] == LIGHT_Y)) ||
                   ((prev[i] == LIGHT_Y) && (lt[i] == LIGHT_G));
      short_v[i] = (prev[i] == LIGHT_Y) && (lt[i] == LIGHT_R) &&
                   (32'(ycnt[i]) < MIN_YELLOW);
    end
    conf   = !$onehot0(act_v);
    bad_in = conf || (|inv_v);
    // pcnt holds the preceding run of bad samples; this sample completes the run
    filt_hit = (32'(pcnt) + 32'd1) >= CONFLICT_FILTER;

    hit      = 1'b1;
    hit_code = '0;
    hit_dir  = '0;
    if (filt_hit && conf) begin
      hit_code = 3'd2;
      hit_dir  = lowest(act_v);
    end else if (filt_hit && (|inv_v)) begin
      hit_code = 3'd1;
      hit_dir  = lowest(inv_v);
    end else if (|skip_v) begin
      hit_code = 3'd3;
      hit_dir  = lowest(skip_v);
    end else if (|order_v) begin
      hit_code = 3'd4;
      hit_dir  = lowest(order_v);
    end else if (|short_v) begin
      hit_code = 3'd5;
      hit_dir  = lowest(short_v);
    end else begin
      hit = 1'b0;
    end

    fcnt_nxt = (fcnt == FW'(2 * FLASH_HALF - 1)) ? '0 : fcnt + FW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      fault      <= 1'b0;
      fault_code <= '0;
      fault_dir  <= '0;
      pcnt       <= '0;
      fcnt       <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        prev[i]  <= LIGHT_R;
        out_r[i] <= LIGHT_R;
        ycnt[i]  <= '0;
      end
`ifdef TLC_MON_STATS_EN
      fault_count <= '0;
`endif
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        prev[i] <= lt[i];
        if (lt[i] != LIGHT_Y)
          ycnt[i] <= '0;
        else if (32'(ycnt[i]) < MIN_YELLOW)
          ycnt[i] <= ycnt[i] + YW'(1);
      end
      if (!bad_in)
        pcnt <= '0;
      else if (32'(pcnt) < CONFLICT_FILTER)
        pcnt <= pcnt + PW'(1);

      case (state)
        RUN: begin
          if (hit) begin
            // the latch edge itself is the first red-on flash cycle
            state      <= FLASH;
            fault      <= 1'b1;
            fault_code <= hit_code;
            fault_dir  <= hit_dir;
            fcnt       <= '0;
            for (int unsigned i = 0; i < 4; i++) out_r[i] <= LIGHT_R;
`ifdef TLC_MON_STATS_EN
            if (fault_count != 8'hFF) fault_count <= fault_count + 8'd1;
`endif
          end else begin
            for (int unsigned i = 0; i < 4; i++) out_r[i] <= lt[i];
          end
        end
        FLASH: begin
          if (fault_ack && !bad_in && !hit) begin
            state      <= RUN;
            fault      <= 1'b0;
            fault_code <= '0;
            fault_dir  <= '0;
            pcnt       <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
              out_r[i] <= lt[i];
              ycnt[i]  <= '0;
            end
          end else begin
            fcnt <= fcnt_nxt;
            for (int unsigned i = 0; i < 4; i++)
              out_r[i] <= (32'(fcnt_nxt) < FLASH_HALF) ? LIGHT_R : 3'b000;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign out_N = out_r[0];
  assign out_E = out_r[1];
  assign out_S = out_r[2];
  assign out_W = out_r[3];

endmodule
